// File: rtl/uart_axil_regs.sv
// AXI4-Lite register front-end for the UART core.
// It turns TXDATA writes into single-cycle tx_start pulses, with a one-deep
// holding register. Received bytes are buffered in a small RX FIFO, and the
// block drives the baud prescale value.
// Optional feature macro: UART_IRQ_EN adds the IRQ_EN register and a
// registered irq output. Without it, irq is tied low.
module uart_axil_regs #(
  parameter int          DATA_WIDTH     = 8,
  parameter int          RX_FIFO_DEPTH  = 4,
  parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [4:0]            s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_ready,
  output logic [15:0]           prescale,
  output logic                  irq
);

  localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] REG_TXDATA   = 3'd0;
  localparam logic [2:0] REG_RXDATA   = 3'd1;
  localparam logic [2:0] REG_STATUS   = 3'd2;
  localparam logic [2:0] REG_PRESCALE = 3'd3;
  localparam logic [2:0] REG_IRQ_EN   = 3'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_PEND, TX_START, TX_WAIT} tx_state_t;
  tx_state_t tx_state;

  logic [2:0]            wr_sel;
  logic [2:0]            rd_sel;
  logic                  wr_hs;
  logic                  rd_hs;
  logic [DATA_WIDTH-1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_pop;
  logic                  fifo_push;
  logic                  overrun_set;
  logic                  tx_write;
  logic                  tx_accept;
  logic                  overflow_set;
  logic                  status_w1c;
  logic                  rx_overrun;
  logic                  tx_overflow;
  logic [31:0]           status_value;
  logic [31:0]           rd_value;
  logic [1:0]            rd_resp;
  logic                  unused_bits;

  // The handshake completes in the cycle the registered ready pulse is high.
  assign wr_sel = s_axil_awaddr[4:2];
  assign rd_sel = s_axil_araddr[4:2];
  assign wr_hs  = s_axil_awready & s_axil_awvalid & s_axil_wvalid;
  assign rd_hs  = s_axil_arready & s_axil_arvalid;

  // The pointers carry one extra wrap bit, so full and empty can be told apart.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign fifo_pop    = rd_hs && (rd_sel == REG_RXDATA) && !fifo_empty;
  assign fifo_push   = rx_ready && (!fifo_full || fifo_pop);
  assign overrun_set = rx_ready && fifo_full && !fifo_pop;

  assign tx_write     = wr_hs && (wr_sel == REG_TXDATA) && s_axil_wstrb[0];
  assign tx_accept    = tx_write && (tx_state == TX_IDLE);
  assign overflow_set = tx_write && (tx_state != TX_IDLE);
  assign status_w1c   = wr_hs && (wr_sel == REG_STATUS) && s_axil_wstrb[0];

  assign status_value = {26'd0, tx_overflow, rx_overrun, fifo_full, ~fifo_empty,
                         (tx_state != TX_IDLE), tx_busy};

  assign unused_bits = ^{s_axil_wdata[31:16], s_axil_wstrb[3:2],
                         s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  // Read data mux; unmapped offsets return zero with SLVERR.
  always_comb begin
    rd_value = 32'd0;
    rd_resp  = RESP_OKAY;
    case (rd_sel)
      REG_TXDATA:   rd_value = 32'd0;
      REG_RXDATA: begin
        if (!fifo_empty) begin
          rd_value[8]              = 1'b1;
          rd_value[DATA_WIDTH-1:0] = fifo_mem[rd_ptr[PTR_W-1:0]];
        end
      end
      REG_STATUS:   rd_value = status_value;
      REG_PRESCALE: rd_value = {16'd0, prescale};
      REG_IRQ_EN: begin
`ifdef UART_IRQ_EN
        rd_value = {29'd0, irq_en};
`endif
      end
      default:      rd_resp = RESP_SLVERR;
    endcase
  end

  // Write channel: accept AW and W together, then hold B until bready.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
    end else begin
      s_axil_awready <= s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid && !s_axil_awready;
      s_axil_wready  <= s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid && !s_axil_awready;
      if (wr_hs) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= (wr_sel > REG_IRQ_EN) ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
    end
  end

  // Read channel: register data and response, then hold them until rready.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= 32'd0;
      s_axil_rresp   <= RESP_OKAY;
    end else begin
      s_axil_arready <= s_axil_arvalid && !s_axil_rvalid && !s_axil_arready;
      if (rd_hs) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= rd_value;
        s_axil_rresp  <= rd_resp;
      end else if (s_axil_rvalid && s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

  // PRESCALE register with per-byte-lane writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= PRESCALE_RESET;
    end else if (wr_hs && (wr_sel == REG_PRESCALE)) begin
      if (s_axil_wstrb[0]) prescale[7:0]  <= s_axil_wdata[7:0];
      if (s_axil_wstrb[1]) prescale[15:8] <= s_axil_wdata[15:8];
    end
  end

  // Sticky error flags; a new set beats a simultaneous write-one-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      rx_overrun  <= (rx_overrun  && !(status_w1c && s_axil_wdata[4])) || overrun_set;
      tx_overflow <= (tx_overflow && !(status_w1c && s_axil_wdata[5])) || overflow_set;
    end
  end

  // TX holding FSM; tx_start is registered one cycle after START.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_accept) begin
            tx_data  <= s_axil_wdata[DATA_WIDTH-1:0];
            tx_state <= TX_PEND;
          end
        end
        TX_PEND: begin
          if (!tx_busy) tx_state <= TX_START;
        end
        TX_START: begin
          tx_start <= 1'b1;
          tx_state <= TX_WAIT;
        end
        TX_WAIT: tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // RX FIFO storage; this is data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr[PTR_W-1:0]] <= rx_data;
  end

`ifdef UART_IRQ_EN
  logic [2:0] irq_en;

  // Interrupt enables and the registered interrupt output.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= 3'd0;
      irq    <= 1'b0;
    end else begin
      if (wr_hs && (wr_sel == REG_IRQ_EN) && s_axil_wstrb[0]) irq_en <= s_axil_wdata[2:0];
      irq <= |(irq_en & {rx_overrun | tx_overflow, (tx_state == TX_IDLE), ~fifo_empty});
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_axil_regs.sv
// Self-checking bench for uart_axil_regs. It uses a transaction-level model
// (byte queue, flags, TX timing rule) plus directed, hand-computed expectations.
// Build with +define+UART_IRQ_EN to exercise the interrupt feature.
module tb_uart_axil_regs;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [15:0] prescale;
  logic        irq;

  uart_axil_regs #(.DATA_WIDTH(8), .RX_FIFO_DEPTH(DEPTH), .PRESCALE_RESET(16'd0)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_ready(rx_ready), .prescale(prescale), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse_cyc = -1;
  int hs_cyc = -1;

  // Model state
  logic [7:0]  m_q[$];
  logic        m_ovr, m_ofl;
  logic [15:0] m_presc;
  logic [7:0]  m_txd;
  int          m_tx_st;      // 0 idle, 1 waiting for !tx_busy, 2 start scheduled
  int          m_start_cyc, m_idle_cyc;
  logic [2:0]  m_irq_en;
  logic        exp_irq;
  logic [1:0]  exp_b[$];
  logic [31:0] exp_rd[$];
  logic [1:0]  exp_rr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock edge of the model; it is evaluated with the values held just before the edge.
  task automatic model_step();
    logic        pend;
    logic        ovr_set, ofl_set;
    logic [2:0]  sel;
    logic [31:0] v;
    logic [1:0]  r;
    if (rst) begin
      m_q.delete(); exp_b.delete(); exp_rd.delete(); exp_rr.delete();
      m_ovr = 0; m_ofl = 0; m_presc = 16'h0000; m_txd = 8'h00;
      m_tx_st = 0; m_start_cyc = -10; m_idle_cyc = -10; m_irq_en = 3'd0; exp_irq = 0;
      return;
    end
    pend = (m_tx_st != 0);
    ovr_set = 0; ofl_set = 0;
    v = 32'd0;
    v[2] = |(m_irq_en & {m_ovr | m_ofl, !pend, m_q.size() != 0});
    exp_irq = v[2];
    if (arready && arvalid) begin
      sel = araddr[4:2]; v = 32'd0; r = 2'b00;
      case (sel)
        3'd1: if (m_q.size() != 0) v = 32'h100 | {24'd0, m_q.pop_front()};
        3'd2: v = {26'd0, m_ofl, m_ovr, m_q.size() == DEPTH, m_q.size() != 0, pend, tx_busy};
        3'd3: v = {16'd0, m_presc};
        3'd4: v = {29'd0, m_irq_en};
        3'd5, 3'd6, 3'd7: r = 2'b10;
        default: v = 32'd0;
      endcase
      exp_rd.push_back(v); exp_rr.push_back(r);
    end
    if (rx_ready) begin
      if (m_q.size() < DEPTH) m_q.push_back(rx_data);
      else ovr_set = 1;
    end
    // TX timing: the first idle-busy cycle c after a latch gives tx_start in c+2 and idle from c+3.
    if (m_tx_st == 1 && !tx_busy) begin
      m_start_cyc = cyc + 2; m_idle_cyc = cyc + 3; m_tx_st = 2;
    end else if (m_tx_st == 2 && cyc + 1 == m_idle_cyc) begin
      m_tx_st = 0;
    end
    if (awready && awvalid && wvalid) begin
      sel = awaddr[4:2];
      exp_b.push_back(sel > 3'd4 ? 2'b10 : 2'b00);
      case (sel)
        3'd0: if (wstrb[0]) begin
          if (pend) ofl_set = 1;
          else begin m_txd = wdata[7:0]; m_tx_st = 1; end
        end
        3'd2: if (wstrb[0]) begin
          if (wdata[4]) m_ovr = 0;
          if (wdata[5]) m_ofl = 0;
        end
        3'd3: begin
          if (wstrb[0]) m_presc[7:0] = wdata[7:0];
          if (wstrb[1]) m_presc[15:8] = wdata[15:8];
        end
`ifdef UART_IRQ_EN
        3'd4: if (wstrb[0]) m_irq_en = wdata[2:0];
`endif
        default: ;
      endcase
    end
    if (ovr_set) m_ovr = 1;
    if (ofl_set) m_ofl = 1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      cyc++;
    end
  end

  // Per-cycle comparison of the free-running outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin pulses++; last_pulse_cyc = cyc; end
      if (!rst) begin
        chk("tx_start", 32'(tx_start), 32'(cyc == m_start_cyc));
        chk("tx_data", 32'(tx_data), 32'(m_txd));
        chk("prescale", 32'(prescale), 32'(m_presc));
        chk("irq", 32'(irq), 32'(exp_irq));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic aw_phase(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("awready", 32'(awready), 32'd1);
    chk("wready", 32'(wready), 32'd1);
    hs_cyc = cyc;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
  endtask

  task automatic b_phase(input bit do_ready);
    int n;
    logic [1:0] e;
    @(negedge clk);
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    chk("bvalid", 32'(bvalid), 32'd1);
    if (exp_b.size() == 0) begin
      failures++; $display("FAIL bresp_queue actual=empty required=entry");
    end else begin
      e = exp_b.pop_front();
      chk("bresp", 32'(bresp), 32'(e));
    end
    if (do_ready) begin
      bready = 1;
      @(posedge clk); #1;
      bready = 0;
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    aw_phase(a, d, s);
    b_phase(1'b1);
  endtask

  task automatic axi_read(input logic [4:0] a, input bit push_en, input logic [7:0] push_b,
                          output logic [31:0] d, output logic [1:0] r);
    int n;
    logic [31:0] ed;
    logic [1:0]  er;
    @(negedge clk);
    araddr = a; arvalid = 1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk("arready", 32'(arready), 32'd1);
    if (push_en) begin rx_data = push_b; rx_ready = 1; end
    @(posedge clk); #1;
    arvalid = 0; rx_ready = 0;
    @(negedge clk);
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    chk("rvalid", 32'(rvalid), 32'd1);
    if (exp_rd.size() == 0) begin
      failures++; $display("FAIL rdata_queue actual=empty required=entry");
    end else begin
      ed = exp_rd.pop_front(); er = exp_rr.pop_front();
      chk("rdata_model", rdata, ed);
      chk("rresp_model", 32'(rresp), 32'(er));
    end
    d = rdata; r = rresp;
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_ready = 1;
    @(negedge clk);
    rx_ready = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [31:0] d;
  logic [1:0]  r;
  logic [31:0] exp_list[5];

  initial begin
    rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0; tx_busy = 0; rx_data = 0; rx_ready = 0;
    idle(3);
    // Reset state
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_prescale", 32'(prescale), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(posedge clk); #1; rst = 0;

    // Single TXDATA write with the transmitter idle
    axi_write(5'h00, 32'h0000_0055, 4'b0001);
    idle(6);
    chk("tx55_pulses", 32'(pulses), 32'd1);
    chk("tx55_latency", 32'(last_pulse_cyc - hs_cyc), 32'd3);
    chk("tx55_data", 32'(tx_data), 32'h55);
    axi_read(5'h08, 0, 8'h00, d, r);
    chk("status_idle", d, 32'h0);

    // Holding register, overflow and W1C
    tx_busy = 1;
    axi_write(5'h00, 32'h0000_00A1, 4'b0001);
    axi_write(5'h00, 32'h0000_00B2, 4'b0001);
    idle(4);
    chk("busy_no_pulse", 32'(pulses), 32'd1);
    axi_read(5'h08, 0, 8'h00, d, r);
    chk("status_ofl", d, 32'h23);
    tx_busy = 0;
    idle(6);
    chk("a1_pulses", 32'(pulses), 32'd2);
    chk("a1_data", 32'(tx_data), 32'hA1);
    axi_write(5'h08, 32'h0000_0020, 4'b0001);
    axi_read(5'h08, 0, 8'h00, d, r);
    chk("status_cleared", d, 32'h0);

    // RX FIFO fill, overrun and drain
    rx_pulse(8'h11); rx_pulse(8'h22); rx_pulse(8'h33); rx_pulse(8'h44); rx_pulse(8'h66);
    axi_read(5'h08, 0, 8'h00, d, r);
    chk("status_full_ovr", d, 32'h1C);
    exp_list = '{32'h111, 32'h122, 32'h133, 32'h144, 32'h000};
    for (int i = 0; i < 5; i++) begin
      axi_read(5'h04, 0, 8'h00, d, r);
      chk("rxdata_drain", d, exp_list[i]);
    end
    axi_write(5'h08, 32'h0000_0010, 4'b0001);

    // Push and pop in the same cycle on a full FIFO
    rx_pulse(8'hA0); rx_pulse(8'hA1); rx_pulse(8'hA2); rx_pulse(8'hA3);
    axi_read(5'h04, 1, 8'h77, d, r);
    chk("rx_full_pushpop", d, 32'h1A0);
    axi_read(5'h08, 0, 8'h00, d, r);
    chk("status_full_noovr", d, 32'h0C);
    exp_list = '{32'h1A1, 32'h1A2, 32'h1A3, 32'h177, 32'h000};
    for (int i = 0; i < 5; i++) begin
      axi_read(5'h04, 0, 8'h00, d, r);
      chk("rxdata_drain2", d, exp_list[i]);
    end
    // Push and pop in the same cycle on an empty FIFO
    axi_read(5'h04, 1, 8'h3E, d, r);
    chk("rx_empty_pushpop", d, 32'h0);
    axi_read(5'h04, 0, 8'h00, d, r);
    chk("rx_empty_stored", d, 32'h13E);

    // PRESCALE lanes, unmapped accesses, TXDATA read
    axi_write(5'h0C, 32'h1234_0364, 4'b0001);
    chk("prescale_lane0", 32'(prescale), 32'h0064);
    axi_write(5'h0C, 32'h0000_BEEF, 4'b0011);
    axi_read(5'h0C, 0, 8'h00, d, r);
    chk("prescale_read", d, 32'hBEEF);
    axi_read(5'h1C, 0, 8'h00, d, r);
    chk("unmapped_rdata", d, 32'h0);
    chk("unmapped_rresp", 32'(r), 32'h2);
    axi_write(5'h18, 32'hFFFF_FFFF, 4'b1111);
    chk("unmapped_wr_bresp", 32'(bresp), 32'h2);
    axi_read(5'h00, 0, 8'h00, d, r);
    chk("txdata_reads0", d, 32'h0);

    // A stalled B channel blocks the next write
    aw_phase(5'h0C, 32'h0000_0005, 4'b0011);
    b_phase(1'b0);
    @(negedge clk);
    awaddr = 5'h0C; wdata = 32'h0000_0007; wstrb = 4'b0011; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bvalid_held", 32'(bvalid), 32'd1);
      chk("aw_blocked", 32'(awready), 32'd0);
    end
    chk("prescale_hold", 32'(prescale), 32'h5);
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    aw_phase(5'h0C, 32'h0000_0007, 4'b0011);
    b_phase(1'b1);
    chk("prescale_second", 32'(prescale), 32'h7);

`ifdef UART_IRQ_EN
    axi_write(5'h10, 32'h0000_0001, 4'b0001);
    axi_read(5'h10, 0, 8'h00, d, r);
    chk("irq_en_read", d, 32'h1);
    chk("irq_before", 32'(irq), 32'd0);
    rx_pulse(8'h5A);
    chk("irq_not_yet", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_asserted", 32'(irq), 32'd1);
    axi_read(5'h04, 0, 8'h00, d, r);
    chk("irq_rxdata", d, 32'h15A);
    idle(2);
    chk("irq_cleared", 32'(irq), 32'd0);
`else
    axi_write(5'h10, 32'h0000_0007, 4'b0001);
    chk("irq_en_bresp", 32'(bresp), 32'h0);
    axi_read(5'h10, 0, 8'h00, d, r);
    chk("irq_en_reads0", d, 32'h0);
    chk("irq_tied", 32'(irq), 32'd0);
`endif

    // Reset during a pending transmit with data in the FIFO
    tx_busy = 1;
    axi_write(5'h00, 32'h0000_003C, 4'b0001);
    rx_pulse(8'h9D);
    @(posedge clk); #1; rst = 1;
    idle(2);
    @(posedge clk); #1; rst = 0;
    tx_busy = 0;
    idle(6);
    chk("rst_drops_tx", 32'(pulses), 32'd2);
    chk("rst_tx_data_mid", 32'(tx_data), 32'd0);
    axi_read(5'h08, 0, 8'h00, d, r);
    chk("rst_flushed", d, 32'h0);
    axi_read(5'h04, 0, 8'h00, d, r);
    chk("rst_fifo_empty", d, 32'h0);

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
